// File: rtl/devil_sched_pkg.sv
// rtl/devil_sched_pkg.sv - shared encodings and helpers for the trigger scheduler
package devil_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LAUNCH   = 2'd1,
    ST_WAIT_END = 2'd2,
    ST_DONE     = 2'd3
  } sched_state_e;

  localparam int STAT_STATE_LSB    = 0;
  localparam int STAT_BUSY_BIT     = 2;
  localparam int STAT_LAST_ERR_BIT = 3;
  localparam int STAT_GRANT_LSB    = 4;
  localparam int STAT_ERRCNT_LSB   = 8;
  localparam int STAT_DONECNT_LSB  = 16;

  localparam int STAT_GRANT_W = 4;
  localparam int ERR_CNT_W    = 8;
  localparam int DONE_CNT_W   = 16;

  function automatic logic [31:0] pack_status(
    input logic [1:0]            state,
    input logic                  busy,
    input logic                  last_err,
    input logic [STAT_GRANT_W-1:0] grant,
    input logic [ERR_CNT_W-1:0]  err_cnt,
    input logic [DONE_CNT_W-1:0] done_cnt
  );
    logic [31:0] s;
    s = '0;
    s[STAT_STATE_LSB +: 2]               = state;
    s[STAT_BUSY_BIT]                     = busy;
    s[STAT_LAST_ERR_BIT]                 = last_err;
    s[STAT_GRANT_LSB +: STAT_GRANT_W]    = grant;
    s[STAT_ERRCNT_LSB +: ERR_CNT_W]      = err_cnt;
    s[STAT_DONECNT_LSB +: DONE_CNT_W]    = done_cnt;
    return s;
  endfunction

endpackage

// File: rtl/devil_trigger_scheduler_rr_arbiter.sv
// rtl/devil_trigger_scheduler_rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter
  import devil_sched_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int REQ_ID_W = 1
) (
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [REQ_ID_W-1:0] i_ptr,
  output logic [NUM_REQ-1:0]  o_grant,
  output logic [REQ_ID_W-1:0] o_grant_id,
  output logic                o_valid
);

  always_comb begin
    int                  w_idx;
    logic [REQ_ID_W-1:0] w_sel;
    o_grant    = '0;
    o_grant_id = '0;
    o_valid    = 1'b0;
    w_idx      = 0;
    w_sel      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = (int'(i_ptr) + i) % NUM_REQ;
      w_sel = REQ_ID_W'(w_idx);
      if (!o_valid && i_req[w_sel]) begin
        o_grant[w_sel] = 1'b1;
        o_grant_id     = w_sel;
        o_valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/devil_trigger_scheduler.sv
// rtl/devil_trigger_scheduler.sv - shares the active-attack engine between requesters
module devil_trigger_scheduler
  import devil_sched_pkg::*;
#(
  parameter int C_ACE_ADDR_WIDTH   = 44,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_REQ            = 2,
  parameter int REQ_ID_W           = 1,
  parameter int TIMEOUT_W          = 16
) (
  input  logic                                  ace_aclk,
  input  logic                                  ace_aresetn,
  input  logic                                  i_enable,
  input  logic [TIMEOUT_W-1:0]                  i_timeout_reg,
  input  logic [NUM_REQ-1:0]                    i_req_valid,
  output logic [NUM_REQ-1:0]                    o_req_ready,
  input  logic [NUM_REQ*C_ACE_ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [NUM_REQ*4-1:0]                  i_req_snoop,
  input  logic [NUM_REQ*4-1:0]                  i_req_func,
  input  logic                                  i_snooping,
  input  logic                                  i_engine_busy,
  input  logic                                  i_engine_end,
  output logic                                  o_trigger,
  output logic [C_ACE_ADDR_WIDTH-1:0]           o_araddr,
  output logic [3:0]                            o_arsnoop,
  output logic [3:0]                            o_func,
  output logic [REQ_ID_W-1:0]                   o_grant_id,
  output logic [NUM_REQ-1:0]                    o_done,
  output logic                                  o_done_err,
  output logic                                  o_busy,
  output logic [C_S_AXI_DATA_WIDTH-1:0]         o_status
);

  sched_state_e                r_state;
  logic [REQ_ID_W-1:0]         r_rr_ptr;
  logic [REQ_ID_W-1:0]         r_grant_id;
  logic [C_ACE_ADDR_WIDTH-1:0] r_araddr;
  logic [3:0]                  r_arsnoop;
  logic [3:0]                  r_func;
  logic                        r_trigger;
  logic [NUM_REQ-1:0]          r_done;
  logic                        r_done_err;
  logic                        r_last_err;
  logic [TIMEOUT_W-1:0]        r_wdog;
  logic [DONE_CNT_W-1:0]       r_done_cnt;
  logic [ERR_CNT_W-1:0]        r_err_cnt;

  logic [NUM_REQ-1:0]          w_grant;
  logic [REQ_ID_W-1:0]         w_grant_id;
  logic                        w_grant_valid;
  logic                        w_eligible;
  logic                        w_handshake;
  logic                        w_tmo_hit;
  logic [REQ_ID_W-1:0]         w_next_ptr;
  logic [C_ACE_ADDR_WIDTH-1:0] w_sel_addr;
  logic [3:0]                  w_sel_snoop;
  logic [3:0]                  w_sel_func;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .REQ_ID_W (REQ_ID_W)
  ) u_arb (
    .i_req      (i_req_valid),
    .i_ptr      (r_rr_ptr),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id),
    .o_valid    (w_grant_valid)
  );

  // Reset gates the accept so o_req_ready is low while ace_aresetn is asserted.
  assign w_eligible  = ace_aresetn && (r_state == ST_IDLE) && i_enable &&
                       !i_snooping && !i_engine_busy;
  assign w_handshake = w_eligible && w_grant_valid;
  assign o_req_ready = w_handshake ? w_grant : '0;

  always_comb begin
    w_sel_addr  = '0;
    w_sel_snoop = '0;
    w_sel_func  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) begin
        w_sel_addr  = w_sel_addr  | i_req_addr[k*C_ACE_ADDR_WIDTH +: C_ACE_ADDR_WIDTH];
        w_sel_snoop = w_sel_snoop | i_req_snoop[k*4 +: 4];
        w_sel_func  = w_sel_func  | i_req_func[k*4 +: 4];
      end
    end
  end

  assign w_tmo_hit  = (i_timeout_reg != '0) && (r_wdog == i_timeout_reg - TIMEOUT_W'(1));
  assign w_next_ptr = (r_grant_id == REQ_ID_W'(NUM_REQ-1)) ? '0 : r_grant_id + 1'b1;

  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_araddr   <= '0;
      r_arsnoop  <= '0;
      r_func     <= '0;
      r_trigger  <= 1'b0;
      r_done     <= '0;
      r_done_err <= 1'b0;
      r_last_err <= 1'b0;
      r_wdog     <= '0;
      r_done_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_trigger  <= 1'b0;
      r_done     <= '0;
      r_done_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_handshake) begin
            r_araddr   <= w_sel_addr;
            r_arsnoop  <= w_sel_snoop;
            r_func     <= w_sel_func;
            r_grant_id <= w_grant_id;
            r_wdog     <= '0;
            r_trigger  <= 1'b1;
            r_state    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          r_state <= ST_WAIT_END;
        end
        ST_WAIT_END: begin
          if (r_wdog != '1) begin
            r_wdog <= r_wdog + 1'b1;
          end
          // A real completion takes priority over a simultaneous watchdog expiry.
          if (i_engine_end || w_tmo_hit) begin
            r_done[r_grant_id] <= 1'b1;
            r_done_err         <= !i_engine_end;
            r_state            <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_last_err <= r_done_err;
          r_rr_ptr   <= w_next_ptr;
          if (r_done_cnt != '1) begin
            r_done_cnt <= r_done_cnt + 1'b1;
          end
          if (r_done_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_trigger  = r_trigger;
  assign o_araddr   = r_araddr;
  assign o_arsnoop  = r_arsnoop;
  assign o_func     = r_func;
  assign o_grant_id = r_grant_id;
  assign o_done     = r_done;
  assign o_done_err = r_done_err;
  assign o_busy     = (r_state != ST_IDLE);

  always_comb begin
    o_status       = '0;
    o_status[31:0] = pack_status(r_state, o_busy, r_last_err,
                                 STAT_GRANT_W'(r_grant_id), r_err_cnt, r_done_cnt);
  end

endmodule

// File: tb/tb_devil_trigger_scheduler.sv
// tb/tb_devil_trigger_scheduler.sv - randomized transaction-level bench for the trigger scheduler
module tb_devil_trigger_scheduler;

  localparam int AW = 44;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int IW = 1;
  localparam int TW = 16;

  logic              clk = 1'b0;
  logic              ace_aresetn;
  logic              i_enable;
  logic [TW-1:0]     i_timeout_reg;
  logic [NR-1:0]     i_req_valid;
  logic [NR-1:0]     o_req_ready;
  logic [NR*AW-1:0]  i_req_addr;
  logic [NR*4-1:0]   i_req_snoop;
  logic [NR*4-1:0]   i_req_func;
  logic              i_snooping;
  logic              i_engine_busy;
  logic              i_engine_end;
  logic              o_trigger;
  logic [AW-1:0]     o_araddr;
  logic [3:0]        o_arsnoop;
  logic [3:0]        o_func;
  logic [IW-1:0]     o_grant_id;
  logic [NR-1:0]     o_done;
  logic              o_done_err;
  logic              o_busy;
  logic [DW-1:0]     o_status;

  int n_checks = 0;
  int n_fail   = 0;

  int m_ptr, m_cnt, m_err, m_last_err;

  always #5 clk = ~clk;

  devil_trigger_scheduler #(
    .C_ACE_ADDR_WIDTH   (AW),
    .C_S_AXI_DATA_WIDTH (DW),
    .NUM_REQ            (NR),
    .REQ_ID_W           (IW),
    .TIMEOUT_W          (TW)
  ) dut (
    .ace_aclk      (clk),
    .ace_aresetn   (ace_aresetn),
    .i_enable      (i_enable),
    .i_timeout_reg (i_timeout_reg),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_addr    (i_req_addr),
    .i_req_snoop   (i_req_snoop),
    .i_req_func    (i_req_func),
    .i_snooping    (i_snooping),
    .i_engine_busy (i_engine_busy),
    .i_engine_end  (i_engine_end),
    .o_trigger     (o_trigger),
    .o_araddr      (o_araddr),
    .o_arsnoop     (o_arsnoop),
    .o_func        (o_func),
    .o_grant_id    (o_grant_id),
    .o_done        (o_done),
    .o_done_err    (o_done_err),
    .o_busy        (o_busy),
    .o_status      (o_status)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [NR-1:0] v, input int p);
    for (int i = 0; i < NR; i++) begin
      if (v[(p + i) % NR]) return (p + i) % NR;
    end
    return 0;
  endfunction

  function automatic logic [31:0] exp_status(input int w);
    return 32'((m_cnt << 16) | (m_err << 8) | (w << 4) | (m_last_err << 3));
  endfunction

  // d: cycles from trigger to engine end (>=1); tmo: watchdog limit (0 = off)
  task automatic run_txn(input logic [NR-1:0] vmask, input int blk, input int d, input int tmo);
    logic [AW-1:0] a [NR];
    logic [3:0]    s [NR];
    logic [3:0]    f [NR];
    int            w, done_k, sel;
    logic          exp_err;
    for (int r = 0; r < NR; r++) begin
      a[r] = {12'($urandom), $urandom};
      s[r] = 4'($urandom);
      f[r] = 4'($urandom);
      i_req_addr[r*AW +: AW] = a[r];
      i_req_snoop[r*4 +: 4]  = s[r];
      i_req_func[r*4 +: 4]   = f[r];
    end
    i_timeout_reg = TW'(tmo);
    i_req_valid   = vmask;
    for (int b = 0; b < blk; b++) begin
      sel = $urandom_range(1, 7);
      i_snooping    = sel[0];
      i_engine_busy = sel[1];
      i_enable      = !sel[2];
      #1;
      check_eq("blocked_ready", o_req_ready, 0);
      check_eq("blocked_busy", o_busy, 0);
      tick;
    end
    i_snooping = 1'b0; i_engine_busy = 1'b0; i_enable = 1'b1;
    #1;
    w = rr_pick(vmask, m_ptr);
    check_eq("handshake_ready", o_req_ready, 64'(1) << w);
    tick;
    i_req_valid  = '0;
    i_enable     = $urandom_range(0, 1) != 0;
    i_engine_end = $urandom_range(0, 1) != 0;
    #1;
    check_eq("launch_trigger", o_trigger, 1);
    check_eq("launch_araddr", o_araddr, a[w]);
    check_eq("launch_arsnoop", o_arsnoop, s[w]);
    check_eq("launch_func", o_func, f[w]);
    check_eq("launch_grant_id", o_grant_id, w);
    tick;
    i_enable = 1'b1;
    done_k  = (tmo != 0 && tmo < d) ? tmo : d;
    exp_err = (tmo != 0 && tmo < d);
    for (int k = 0; k < done_k; k++) begin
      i_engine_end = (k == d - 1);
      #1;
      check_eq("wait_no_done", {o_done, o_trigger}, 0);
      tick;
    end
    i_engine_end = 1'b0;
    #1;
    check_eq("done_pulse", o_done, 64'(1) << w);
    check_eq("done_err", o_done_err, exp_err);
    check_eq("done_state", o_status[1:0], 3);
    m_cnt++;
    if (exp_err) m_err++;
    m_last_err = exp_err ? 1 : 0;
    m_ptr = (w + 1) % NR;
    tick;
    #1;
    check_eq("post_status", o_status, exp_status(w));
    check_eq("post_done_clear", o_done, 0);
    check_eq("post_addr_hold", o_araddr, a[w]);
  endtask

  initial begin
    ace_aresetn = 1'b0; i_enable = 1'b1; i_timeout_reg = '0; i_req_valid = '0;
    i_req_addr = '0; i_req_snoop = '0; i_req_func = '0;
    i_snooping = 1'b0; i_engine_busy = 1'b0; i_engine_end = 1'b0;
    m_ptr = 0; m_cnt = 0; m_err = 0; m_last_err = 0;
    tick; tick;
    check_eq("reset_status", o_status, 0);
    check_eq("reset_outputs", {o_araddr, o_arsnoop, o_func, o_trigger, o_done, o_busy}, 0);
    ace_aresetn = 1'b1;

    run_txn(2'b01, 0, 9, 0);
    for (int t = 0; t < 4; t++) run_txn(2'b11, 0, 5, 0);
    run_txn(2'b11, 4, 3, 0);
    run_txn(2'b10, 0, 40, 8);
    run_txn(2'b01, 0, 30, 0);
    run_txn(2'b11, 0, 6, 6);
    run_txn(2'b11, 0, 1, 1);
    for (int t = 0; t < 12; t++) begin
      run_txn(NR'($urandom_range(1, 3)), $urandom_range(0, 3),
              $urandom_range(1, 20), $urandom_range(0, 20));
    end

    if (m_ptr != 1) run_txn(2'b01, 0, 2, 0);
    i_req_valid = 2'b11; i_timeout_reg = '0;
    #1;
    check_eq("rst_pre_ready", o_req_ready, 2'b10);
    tick;
    i_req_valid = 2'b00;
    #1;
    check_eq("rst_pre_trigger", o_trigger, 1);
    tick; tick; tick;
    #3;
    ace_aresetn = 1'b0;
    i_req_valid = 2'b11;
    #1;
    check_eq("rst_async_ready", o_req_ready, 0);
    check_eq("rst_async_status", o_status, 0);
    check_eq("rst_async_outputs",
             {o_araddr, o_arsnoop, o_func, o_grant_id, o_trigger, o_done, o_done_err, o_busy}, 0);
    tick; tick;
    ace_aresetn = 1'b1;
    i_req_valid = 2'b00;
    m_ptr = 0; m_cnt = 0; m_err = 0; m_last_err = 0;
    for (int c = 0; c < 15; c++) begin
      #1;
      check_eq("post_rst_quiet", {o_done, o_busy}, 0);
      tick;
    end
    run_txn(2'b11, 0, 4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
